if_fetch_stage: RTL
===================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Holds the fetch PC and issues single-outstanding requests on the instruction memory bus (req/gnt/rvalid).
- Presents the fetched PC/instruction pair to IF/ID, and obeys the flow-controller flush (btype/jtype) and stall flags.
- Includes a 1-entry skid buffer so a response that lands during a stall is never lost.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
INST_NOP, 32'h0000_0013, instruction driven when no valid instruction (addi x0,x0,0)

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
fc_flush_btype_flag_i  input  1  taken branch resolved in EX; redirect to ex_btype_target_i
fc_flush_jtype_flag_i  input  1  jump resolved in ID; redirect to id_jtype_target_i
fc_stall_flag_i  input  1  downstream stall; hold outputs
ex_btype_target_i  input  32  branch target
id_jtype_target_i  input  32  jump target
if_mem_req_o  output  1  fetch request
if_mem_addr_o  output  32  fetch address (word aligned)
if_mem_gnt_i  input  1  request accepted this cycle
if_mem_rvalid_i  input  1  read data valid
if_mem_rdata_i  input  32  read data
if_pc_o  output  32  PC of presented instruction (to IF/ID if_pc_i)
if_inst_o  output  32  presented instruction
if_valid_o  output  1  if_pc_o/if_inst_o hold a real instruction

Behaviour:
- Reset (rst_n low at posedge clk):
  - state=IDLE, fetch_pc=RESET_PC, discard=0, skid empty.
  - Outputs: if_mem_req_o=0, if_mem_addr_o=RESET_PC, if_pc_o=0, if_inst_o=INST_NOP, if_valid_o=0.
  - Reset mid-transaction abandons it; a later rvalid for it is ignored because state is IDLE.
- FSM (registered):
  - IDLE: go to REQ the cycle after reset deasserts.
  - REQ: if_mem_req_o=1, addr=fetch_pc. On gnt: go to WAIT, fetch_pc+=4 (wraps mod 2^32).
  - WAIT: req=0. On rvalid: go to REQ if slot free, else HOLD.
  - HOLD: req=0. Go to REQ once the skid is empty and not stalled.
- Issue rule: REQ is not entered while the skid buffer is full.
  - At most one request is outstanding.
  - Best-case throughput is 1 instruction / 2 cycles with gnt and rvalid each taking 1 cycle.
- Response routing on rvalid with discard=0:
  - Not stalled and skid empty: output regs load {pc, rdata}, if_valid_o=1 next cycle.
  - Otherwise the response is written to the skid buffer.
- Stall:
  - Output regs hold value.
  - No new request is issued.
  - A granted request still completes into the skid buffer.
- Skid drain: the first non-stalled cycle with skid full moves the skid into the output regs and empties the skid.
- Consumption: a non-stalled cycle with no new data sets if_valid_o=0, if_inst_o=INST_NOP, if_pc_o=0.
- Flush (either flag), with priority over stall:
  - Next fetch_pc = btype target if btype flag is set, else jtype target. Btype wins when both are set, because EX is older.
  - Output regs and skid clear (valid=0, NOP, pc=0).
  - State WAIT: set discard=1; stay in WAIT; the next rvalid is dropped and clears discard; then go to REQ.
  - State REQ without gnt: address changes to the target next cycle and req stays high.
  - State REQ with gnt in the same cycle: the granted request is marked discard.
  - Flush and rvalid in the same cycle: the data is dropped.
- Target bits [1:0] are forced to 0 on if_mem_addr_o.

Optional Feature:
- FETCH_PERF_CNT_EN defined: adds two 32-bit output ports, both wrapping and both reset to 0.
  - if_fetch_cnt_o increments on each accepted (non-discarded) rvalid.
  - if_discard_cnt_o increments on each dropped rvalid.
- Undefined: these ports and counters do not exist; the rest of the behaviour is identical.

Test Plan:
- Reset, then gnt and rvalid each 1 cycle after req, rdata=PC^32'hA5A5_0000 -> addrs 0,4,8 in order; if_valid_o pulses with if_pc_o=0,4,8 and matching inst.
- Stall held 4 cycles while a request is outstanding for pc=0x10 -> outputs frozen; response captured in skid; no req during stall; pc=0x10 appears the cycle after stall drops.
- btype flush with target 0x100 while in WAIT for pc=0x20 -> the 0x20 response is dropped (not on outputs); next req addr=0x100; if_valid_o=0 in the flush cycle +1.
- btype (0x200) and jtype (0x300) asserted together -> next fetch addr=0x200.
- Reset asserted in WAIT, then a stray rvalid -> ignored; first req after reset uses RESET_PC.
- FETCH_PERF_CNT_EN: 3 accepted fetches plus 1 flushed fetch -> if_fetch_cnt_o=3, if_discard_cnt_o=1.

Source files
------------

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: single-outstanding instruction fetch with 1-entry skid buffer feeding IF/ID.
// Define FETCH_PERF_CNT_EN to add accepted/dropped response counters.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] INST_NOP = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fc_flush_btype_flag_i,
  input  logic        fc_flush_jtype_flag_i,
  input  logic        fc_stall_flag_i,
  input  logic [31:0] ex_btype_target_i,
  input  logic [31:0] id_jtype_target_i,
  output logic        if_mem_req_o,
  output logic [31:0] if_mem_addr_o,
  input  logic        if_mem_gnt_i,
  input  logic        if_mem_rvalid_i,
  input  logic [31:0] if_mem_rdata_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_valid_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] if_fetch_cnt_o,
  output logic [31:0] if_discard_cnt_o
`endif
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
  state_t      state, state_n;
  logic [31:0] fetch_pc, pc_n, req_pc, skid_pc, skid_inst, target;
  logic        discard, disc_n, skid_valid, flush, stall, take, rsp, acc, drop;
  assign flush = fc_flush_btype_flag_i | fc_flush_jtype_flag_i;
  assign stall = fc_stall_flag_i;
  assign target = fc_flush_btype_flag_i ? ex_btype_target_i : id_jtype_target_i;
  assign if_mem_req_o = (state == REQ) && !stall;
  assign if_mem_addr_o = fetch_pc & 32'hFFFF_FFFC;
  assign take = if_mem_req_o && if_mem_gnt_i;
  assign rsp = (state == WAIT) && if_mem_rvalid_i;
  assign acc = rsp && !discard && !flush;
  assign drop = rsp && (discard || flush);
  always_comb begin
    state_n = state;
    pc_n = fetch_pc;
    disc_n = discard;
    case (state)
      IDLE: state_n = REQ;
      REQ: if (take) begin
        state_n = WAIT;
        pc_n = fetch_pc + 32'd4;
      end
      WAIT: if (if_mem_rvalid_i) begin
        state_n = (discard || flush || (!stall && !skid_valid)) ? REQ : HOLD;
        disc_n = 1'b0;
      end
      default: state_n = (!skid_valid && !stall) ? REQ : HOLD;
    endcase
    // a redirect kills whatever is in flight; its response must be swallowed
    if (flush) begin
      pc_n = target;
      state_n = (state == HOLD) ? REQ : state_n;
      disc_n = ((state == WAIT) && !if_mem_rvalid_i) || take;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc <= 32'h0;
      discard <= 1'b0;
      skid_valid <= 1'b0;
      skid_pc <= 32'h0;
      skid_inst <= INST_NOP;
      if_valid_o <= 1'b0;
      if_pc_o <= 32'h0;
      if_inst_o <= INST_NOP;
    end else begin
      state <= state_n;
      fetch_pc <= pc_n;
      discard <= disc_n;
      if (take) req_pc <= if_mem_addr_o;
      if (flush) begin
        if_valid_o <= 1'b0;
        if_pc_o <= 32'h0;
        if_inst_o <= INST_NOP;
        skid_valid <= 1'b0;
      end else begin
        if (!stall) begin
          if_valid_o <= skid_valid || acc;
          if_pc_o <= skid_valid ? skid_pc : acc ? req_pc : 32'h0;
          if_inst_o <= skid_valid ? skid_inst : acc ? if_mem_rdata_i : INST_NOP;
        end
        if (acc && (stall || skid_valid)) begin
          skid_valid <= 1'b1;
          skid_pc <= req_pc;
          skid_inst <= if_mem_rdata_i;
        end else if (!stall) skid_valid <= 1'b0;
      end
    end
  end
`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if_fetch_cnt_o <= 32'h0;
      if_discard_cnt_o <= 32'h0;
    end else begin
      if (acc) if_fetch_cnt_o <= if_fetch_cnt_o + 32'd1;
      if (drop) if_discard_cnt_o <= if_discard_cnt_o + 32'd1;
    end
  end
`endif
endmodule
